// File: rtl/counter_control.sv
// counter_control: sequencer for a 16-bit up/down counter register C held in an external datapath.
// Latency: state advances on every rising clk; op/c_ld/c_clr follow the current z/m/pause/abort inputs combinationally.
// Backpressure: pause stalls counting in place; abort returns to IDLE. Build option COUNTER_AUTO_RELOAD_EN makes DONE ping-pong the direction.
module counter_control (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        dir,
  input  logic        pause,
  input  logic        abort,
  input  logic        z,
  input  logic        m,
  output logic        op,
  output logic        c_ld,
  output logic        c_clr,
  output logic        busy,
  output logic        done,
  output logic [15:0] steps,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q;
  logic        dir_q;
  logic [15:0] steps_q;

  // Datapath strobes. z/m reflect the registered C, so C stops exactly at
  // its limit without wrapping. Reset and abort mask the strobes so C keeps
  // its last loaded value.
  always_comb begin
    op    = dir_q;
    c_ld  = 1'b0;
    c_clr = 1'b0;
    case (state_q)
      S_CLR: begin
        c_clr = reset & ~abort;
      end
      S_UP: begin
        op   = 1'b0;
        c_ld = reset & ~abort & ~m & ~pause;
      end
      S_DOWN: begin
        op   = 1'b1;
        c_ld = reset & ~abort & ~z & ~pause;
      end
      default: begin
        op    = dir_q;
        c_ld  = 1'b0;
        c_clr = 1'b0;
      end
    endcase
  end

  // Run sequencing, direction capture and saturating load counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      dir_q   <= 1'b0;
      steps_q <= 16'h0000;
    end else begin
      if (c_ld && (steps_q != 16'hFFFF)) begin
        steps_q <= steps_q + 16'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dir_q   <= dir;
            steps_q <= 16'h0000;
            state_q <= dir ? S_DOWN : S_CLR;
          end
        end
        S_CLR: begin
          state_q <= abort ? S_IDLE : S_UP;
        end
        S_UP: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (m) begin
            state_q <= S_DONE;
          end
        end
        S_DOWN: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (z) begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else begin
`ifdef COUNTER_AUTO_RELOAD_EN
            // Ping-pong: an up run is followed by a down run and vice versa.
            dir_q   <= ~dir_q;
            steps_q <= 16'h0000;
            state_q <= dir_q ? S_CLR : S_DOWN;
`else
            state_q <= S_IDLE;
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign done  = (state_q == S_DONE);
  assign steps = steps_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_control.sv
// Directed bench for counter_control with a behavioural model of register C.
// C is cleared on c_clr, stepped on c_ld, and can be preloaded while the FSM idles.
// Expected values are hand-derived from the run lengths of each scenario.
module tb_counter_control;

  logic        clk;
  logic        reset;
  logic        start;
  logic        dir;
  logic        pause;
  logic        abort;
  logic        z;
  logic        m;
  logic        op;
  logic        c_ld;
  logic        c_clr;
  logic        busy;
  logic        done;
  logic [15:0] steps;
  logic [2:0]  state;

  logic [15:0] c_reg;
  logic        pre_en;
  logic [15:0] pre_val;

  int n_chk;
  int n_pass;

  counter_control dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .dir   (dir),
    .pause (pause),
    .abort (abort),
    .z     (z),
    .m     (m),
    .op    (op),
    .c_ld  (c_ld),
    .c_clr (c_clr),
    .busy  (busy),
    .done  (done),
    .steps (steps),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter register C of the datapath.
  always @(posedge clk) begin
    if (pre_en)     c_reg <= pre_val;
    else if (c_clr) c_reg <= 16'h0000;
    else if (c_ld)  c_reg <= op ? c_reg - 16'd1 : c_reg + 16'd1;
  end

  assign z = (c_reg == 16'h0000);
  assign m = (c_reg == 16'hFFFF);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leave DONE: natural return in the default build, abort when auto-reload would loop.
  task automatic finish_done(input logic [15:0] exp_steps);
`ifdef COUNTER_AUTO_RELOAD_EN
    abort = 1'b1;
`endif
    tick();
    abort = 1'b0;
    chk("done_to_idle_state", {29'd0, state}, 32'd0);
    chk("done_to_idle_done", {31'd0, done}, 32'd0);
    chk("idle_steps_hold", {16'd0, steps}, {16'd0, exp_steps});
  endtask

  int n_ld;
  int guard;
  int op_err;
  logic paused;
  logic [15:0] c0;
  logic [15:0] s0;

  initial begin
    n_chk = 0; n_pass = 0;
    reset = 1'b0; start = 1'b1; dir = 1'b1; pause = 1'b0; abort = 1'b0;
    pre_en = 1'b1; pre_val = 16'h0000;

    // Reset with start held high: reset wins.
    tick(); tick();
    pre_en = 1'b0;
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_op", {31'd0, op}, 32'd0);
    chk("rst_c_ld", {31'd0, c_ld}, 32'd0);
    chk("rst_c_clr", {31'd0, c_clr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_steps", {16'd0, steps}, 32'd0);
    start = 1'b0; dir = 1'b0; reset = 1'b1;
    tick();
    chk("idle_no_start", {29'd0, state}, 32'd0);

    // Full up run with a 3-cycle pause at C=10.
    start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0;
    #1;
    chk("clr_state", {29'd0, state}, 32'd1);
    chk("clr_c_clr", {31'd0, c_clr}, 32'd1);
    chk("clr_c_ld", {31'd0, c_ld}, 32'd0);
    chk("clr_busy", {31'd0, busy}, 32'd1);
    chk("clr_steps", {16'd0, steps}, 32'd0);
    tick();
    chk("up_state", {29'd0, state}, 32'd2);
    chk("up_c_zero", {16'd0, c_reg}, 32'd0);
    n_ld = 0; guard = 0; op_err = 0; paused = 1'b0;
    while (state == 3'd2 && guard < 70000) begin
      if (c_reg == 16'd10 && !paused) begin
        paused = 1'b1; c0 = c_reg; s0 = steps;
        for (int i = 0; i < 3; i++) begin
          pause = 1'b1;
          #1;
          chk("pause_c_ld", {31'd0, c_ld}, 32'd0);
          tick();
        end
        chk("pause_c_hold", {16'd0, c_reg}, {16'd0, c0});
        chk("pause_steps_hold", {16'd0, steps}, {16'd0, s0});
        pause = 1'b0;
        #1;
        chk("pause_resume", {31'd0, c_ld}, 32'd1);
      end
      #1;
      if (c_ld) n_ld++;
      if (op !== 1'b0) op_err++;
      if (m) chk("up_limit_c_ld", {31'd0, c_ld}, 32'd0);
      tick();
      guard++;
    end
    chk("pause_seen", {31'd0, paused}, 32'd1);
    chk("up_op_errs", op_err, 0);
    chk("up_ld_count", n_ld, 65535);
    chk("up_done_state", {29'd0, state}, 32'd4);
    chk("up_done_pulse", {31'd0, done}, 32'd1);
    chk("up_done_c_ld", {31'd0, c_ld}, 32'd0);
    chk("up_steps", {16'd0, steps}, 32'hFFFF);
    chk("up_c_final", {16'd0, c_reg}, 32'hFFFF);
    finish_done(16'hFFFF);

    // Down run from C=5; a start with dir=0 mid-run is ignored.
    pre_en = 1'b1; pre_val = 16'd5;
    tick();
    pre_en = 1'b0;
    start = 1'b1; dir = 1'b1;
    tick();
    dir = 1'b0;
    #1;
    chk("down_state", {29'd0, state}, 32'd3);
    chk("down_op", {31'd0, op}, 32'd1);
    chk("down_steps0", {16'd0, steps}, 32'd0);
    n_ld = c_ld ? 1 : 0;
    tick();
    start = 1'b0;
    #1;
    chk("start_ignored", {29'd0, state}, 32'd3);
    guard = 0; op_err = 0;
    while (state == 3'd3 && guard < 20) begin
      #1;
      if (c_ld) n_ld++;
      if (op !== 1'b1) op_err++;
      tick();
      guard++;
    end
    chk("down_op_errs", op_err, 0);
    chk("down_ld_count", n_ld, 5);
    chk("down_done_state", {29'd0, state}, 32'd4);
    chk("down_done_pulse", {31'd0, done}, 32'd1);
    chk("down_steps", {16'd0, steps}, 32'd5);
    chk("down_c_final", {16'd0, c_reg}, 32'd0);
    finish_done(16'd5);
    chk("idle_op_dir", {31'd0, op}, 32'd1);

    // Down run starting at C=0, then abort inside DONE.
    start = 1'b1; dir = 1'b1;
    tick();
    start = 1'b0;
    #1;
    chk("zero_state", {29'd0, state}, 32'd3);
    chk("zero_c_ld", {31'd0, c_ld}, 32'd0);
    tick();
    chk("zero_done_state", {29'd0, state}, 32'd4);
    chk("zero_done_pulse", {31'd0, done}, 32'd1);
    chk("zero_steps", {16'd0, steps}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_done_state", {29'd0, state}, 32'd0);

    // Abort during DOWN at C=100.
    pre_en = 1'b1; pre_val = 16'd100;
    tick();
    pre_en = 1'b0;
    start = 1'b1; dir = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b1;
    #1;
    chk("abort_c_ld", {31'd0, c_ld}, 32'd0);
    tick();
    abort = 1'b0;
    chk("abort_state", {29'd0, state}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_c_hold", {16'd0, c_reg}, 32'd100);

    // Restart after abort, then reset mid-run at C=7.
    start = 1'b1; dir = 1'b0;
    tick();
    start = 1'b0;
    chk("restart_state", {29'd0, state}, 32'd1);
    tick();
    guard = 0;
    while (c_reg != 16'd7 && guard < 20) begin
      tick();
      guard++;
    end
    chk("reach_c7", {16'd0, c_reg}, 32'd7);
    chk("reach_c7_steps", {16'd0, steps}, 32'd7);
    reset = 1'b0;
    #1;
    chk("rst_mid_c_ld", {31'd0, c_ld}, 32'd0);
    tick();
    chk("rst_mid_state", {29'd0, state}, 32'd0);
    chk("rst_mid_outs", {27'd0, op, c_ld, c_clr, busy, done}, 32'd0);
    chk("rst_mid_steps", {16'd0, steps}, 32'd0);
    chk("rst_mid_c_hold", {16'd0, c_reg}, 32'd7);
    reset = 1'b1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
